// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared widths, opcode enum and data type for reg_calculator
package calc_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;
  localparam int NREGS  = 4;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_RSVD = 3'b011,
    OP_ANDN = 3'b100,
    OP_ORN  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - combinational 4-bit signed ALU; zero/ovf flags under CALC_FLAGS_EN
module calc_alu
  import calc_pkg::*;
(
  input  data_t   a,
  input  data_t   b,
  input  alu_op_e op,
`ifdef CALC_FLAGS_EN
  output logic    zero,
  output logic    ovf,
`endif
  output data_t   y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = a + b;
      OP_RSVD: y = '0;
      OP_ANDN: y = a & ~b;
      OP_ORN:  y = a | ~b;
      OP_SUB:  y = a - b;
      // true signed compare, so -8 < 7 holds even though -8-7 wraps positive
      OP_SLT:  y = (a < b) ? data_t'(1) : data_t'(0);
      default: y = '0;
    endcase
  end

`ifdef CALC_FLAGS_EN
  always_comb begin
    zero = (y == '0);
    ovf  = 1'b0;
    case (op)
      OP_ADD:  ovf = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      OP_SUB:  ovf = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      default: ovf = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/reg_calculator.sv
// rtl/reg_calculator.sv - four-register file feeding calc_alu, written every edge
// Optional flag outputs zero/ovf enabled by CALC_FLAGS_EN.
module reg_calculator
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] immediate,
  input  logic [ADDR_W-1:0] we_addr,
  input  logic [2:0]        control,
`ifdef CALC_FLAGS_EN
  output logic              zero,
  output logic              ovf,
`endif
  output logic [DATA_W-1:0] rd_data
);

  data_t regs [NREGS];
  data_t alu_a;
  data_t alu_y;

  assign alu_a   = regs[rd_addr];
  assign rd_data = alu_a;

  calc_alu u_alu (
    .a    (alu_a),
    .b    (data_t'(immediate)),
    .op   (alu_op_e'(control)),
`ifdef CALC_FLAGS_EN
    .zero (zero),
    .ovf  (ovf),
`endif
    .y    (alu_y)
  );

  // No write enable: holding a value means writing it back through the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      regs[we_addr] <= alu_y;
    end
  end

endmodule

// File: tb/tb_reg_calculator.sv
// tb/tb_reg_calculator.sv - directed self-checking bench for reg_calculator
// Flag checks compile in only when CALC_FLAGS_EN is defined.
module tb_reg_calculator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rd_addr;
  logic [3:0] immediate;
  logic [1:0] we_addr;
  logic [2:0] control;
  logic [3:0] rd_data;
`ifdef CALC_FLAGS_EN
  logic       zero;
  logic       ovf;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [2:0] C_AND = 3'b000, C_OR = 3'b001, C_ADD = 3'b010, C_RSVD = 3'b011;
  localparam logic [2:0] C_ANDN = 3'b100, C_ORN = 3'b101, C_SUB = 3'b110, C_SLT = 3'b111;

  reg_calculator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .immediate (immediate),
    .we_addr   (we_addr),
    .control   (control),
`ifdef CALC_FLAGS_EN
    .zero      (zero),
    .ovf       (ovf),
`endif
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] rd, input logic [3:0] imm,
                       input logic [1:0] we, input logic [2:0] op);
    rd_addr   = rd;
    immediate = imm;
    we_addr   = we;
    control   = op;
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] addr, input logic [3:0] exp);
    rd_addr = addr;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    rst_n = 1'b1;
    rd_addr = 2'd0; immediate = 4'd0; we_addr = 2'd0; control = C_ADD;
    #2 rst_n = 1'b0;
    read_chk("reset_r0", 2'd0, 4'h0);
    read_chk("reset_r1", 2'd1, 4'h0);
    read_chk("reset_r2", 2'd2, 4'h0);
    read_chk("reset_r3", 2'd3, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(2'd0, 4'd2, 2'd0, C_ADD);
    check("r0_add2", rd_data, 4'h2);
    do_op(2'd0, 4'hE, 2'd1, C_SUB);
    read_chk("r1_sub_neg2", 2'd1, 4'h4);
    do_op(2'd1, 4'd1, 2'd2, C_AND);
    read_chk("r2_and1", 2'd2, 4'h0);
    do_op(2'd1, 4'd7, 2'd3, C_SLT);
    read_chk("r3_slt", 2'd3, 4'h1);
    do_op(2'd1, 4'h8, 2'd2, C_ADD);
    read_chk("r2_add_neg8", 2'd2, 4'hC);
    do_op(2'd2, 4'd4, 2'd2, C_SUB);
    read_chk("r2_sub4", 2'd2, 4'h8);
    do_op(2'd2, 4'd7, 2'd0, C_SLT);
    read_chk("slt_wrap", 2'd0, 4'h1);

    do_op(2'd0, 4'd6, 2'd0, C_ADD);
    read_chk("r0_seven", 2'd0, 4'h7);
    rd_addr = 2'd0; immediate = 4'd1; we_addr = 2'd0; control = C_ADD;
    #1;
`ifdef CALC_FLAGS_EN
    check("ovf_add", {3'b0, ovf}, 4'h1);
    check("zero_add", {3'b0, zero}, 4'h0);
`endif
    @(posedge clk); #1;
    check("r0_wrap", rd_data, 4'h8);

    do_op(2'd3, 4'd4, 2'd1, C_ADD);
    read_chk("r1_five", 2'd1, 4'h5);
    do_op(2'd1, 4'd3, 2'd2, C_ANDN);
    read_chk("andn", 2'd2, 4'h4);
    do_op(2'd1, 4'd3, 2'd3, C_ORN);
    read_chk("orn", 2'd3, 4'hD);
    rd_addr = 2'd1; immediate = 4'd3; we_addr = 2'd2; control = C_RSVD;
    #1;
`ifdef CALC_FLAGS_EN
    check("zero_rsvd", {3'b0, zero}, 4'h1);
    check("ovf_rsvd", {3'b0, ovf}, 4'h0);
`endif
    @(posedge clk); #1;
    read_chk("rsvd", 2'd2, 4'h0);

    // Mid-cycle reset, then an edge while reset is held.
    #1 rst_n = 1'b0;
    read_chk("midrst_r0", 2'd0, 4'h0);
    read_chk("midrst_r1", 2'd1, 4'h0);
    read_chk("midrst_r3", 2'd3, 4'h0);
    immediate = 4'd5; we_addr = 2'd0; control = C_ADD; rd_addr = 2'd0;
    @(posedge clk); #1;
    check("edge_in_reset", rd_data, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(2'd0, 4'd3, 2'd1, C_ADD);
    read_chk("hold_init", 2'd1, 4'h3);
    for (int i = 0; i < 3; i++) begin
      do_op(2'd1, 4'd0, 2'd1, C_ADD);
      check("hold", rd_data, 4'h3);
    end

    do_op(2'd1, 4'd1, 2'd0, C_ADD);
    do_op(2'd1, 4'hF, 2'd2, C_ADD);
    do_op(2'd1, 4'd4, 2'd3, C_OR);
    read_chk("sweep_r0", 2'd0, 4'h4);
    read_chk("sweep_r1", 2'd1, 4'h3);
    read_chk("sweep_r2", 2'd2, 4'h2);
    read_chk("sweep_r3", 2'd3, 4'h7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
